// File: rtl/hud_frame_renderer.sv
// hud_frame_renderer
// Per-pixel HUD overlay. The block draws a border ring around the game area and
// lit glyph pixels for a set of text fields in the text band. Stage 1 classifies
// the incoming X/Y and issues the glyph ROM address. The region flags then wait
// ROM_LAT cycles so they line up with the ROM's answer.
//
// Ports
//   clock_25    : pixel clock
//   reset       : synchronous, active-high reset
//   X, Y        : current pixel coordinates (PIX_W bits each)
//   rom_data    : glyph bit returned by the ROM, ROM_LAT cycles after rom_x/rom_y
//   game_over   : game-over status, level-sensitive
//   rom_x       : ROM column address (8 bits)
//   rom_y       : ROM row address (4 bits)
//   field_idx   : index of the hit text field, 0 when no field is hit
//   pixel_on    : pixel lit, 1+ROM_LAT cycles after X/Y
//   game_area_o : pixel lies inside the game area, 1+ROM_LAT cycles after X/Y
//
// Build option
//   HUD_BORDER_BLINK_EN : when defined, the border blinks while game_over is
//                         high (BLINK_HALF frames on, BLINK_HALF frames off).
//                         When undefined, the border is always visible and
//                         game_over is ignored.
module hud_frame_renderer #(
    parameter int PIX_W      = 10,
    parameter int GAME_X0    = 58,
    parameter int GAME_Y0    = 43,
    parameter int GAME_X1    = 678,
    parameter int GAME_Y1    = 448,
    parameter int BORDER_T   = 5,
    parameter int TEXT_Y0    = 460,
    parameter int TEXT_H     = 16,
    parameter int NUM_FIELDS = 2,
    parameter logic [NUM_FIELDS*PIX_W-1:0] FIELD_X0   = {10'd362, 10'd108},
    parameter logic [NUM_FIELDS*PIX_W-1:0] FIELD_W    = {10'd81, 10'd63},
    parameter logic [NUM_FIELDS*PIX_W-1:0] FIELD_BASE = {10'd62, 10'd0},
    parameter int ROM_LAT    = 1,
    parameter int BLINK_HALF = 16
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic [PIX_W-1:0] X,
    input  logic [PIX_W-1:0] Y,
    input  logic             rom_data,
    input  logic             game_over,
    output logic [7:0]       rom_x,
    output logic [3:0]       rom_y,
    output logic [2:0]       field_idx,
    output logic             pixel_on,
    output logic             game_area_o
);

    int xi_s;
    int yi_s;
    logic in_outer_s;
    logic game_s;
    logic border_s;
    logic band_s;
    logic [NUM_FIELDS-1:0] hit_vec_s;
    logic hit_s;
    int   sel_s;
    logic [7:0] rx_s;
    logic [3:0] ry_s;
    logic [2:0] fi_s;
    logic border_vis_s;

    // Stage-1 flags; the ROM address is derived from them
    logic border_r;
    logic text_r;
    logic game_r;

    // Flag delay line matching the ROM latency
    logic [ROM_LAT-1:0] border_d_r;
    logic [ROM_LAT-1:0] text_d_r;
    logic [ROM_LAT-1:0] game_d_r;

    // Region classification and field priority select for the current pixel
    always_comb begin
        xi_s       = int'(X);
        yi_s       = int'(Y);
        in_outer_s = (xi_s >= GAME_X0 - BORDER_T) && (xi_s <= GAME_X1 + BORDER_T) &&
                     (yi_s >= GAME_Y0 - BORDER_T) && (yi_s <= GAME_Y1 + BORDER_T);
        game_s     = (xi_s >= GAME_X0) && (xi_s <= GAME_X1) &&
                     (yi_s >= GAME_Y0) && (yi_s <= GAME_Y1);
        border_s   = in_outer_s && !game_s;
        band_s     = (yi_s >= TEXT_Y0) && (yi_s <= TEXT_Y0 + TEXT_H - 1);
        for (int i = 0; i < NUM_FIELDS; i++) begin
            hit_vec_s[i] = band_s &&
                (xi_s >= int'(FIELD_X0[i*PIX_W +: PIX_W])) &&
                (xi_s <= int'(FIELD_X0[i*PIX_W +: PIX_W]) + int'(FIELD_W[i*PIX_W +: PIX_W]) - 1);
        end
        hit_s = |hit_vec_s;
        // Walk downward so the lowest-index overlapping field is the one kept
        sel_s = 0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (hit_vec_s[i]) begin
                sel_s = i;
            end else begin
                sel_s = sel_s;
            end
        end
        if (hit_s) begin
            rx_s = 8'(xi_s - int'(FIELD_X0[sel_s*PIX_W +: PIX_W]) +
                      int'(FIELD_BASE[sel_s*PIX_W +: PIX_W]));
            ry_s = 4'(yi_s - TEXT_Y0);
            fi_s = 3'(sel_s);
        end else begin
            rx_s = 8'd0;
            ry_s = 4'd0;
            fi_s = 3'd0;
        end
    end

`ifdef HUD_BORDER_BLINK_EN
    localparam int CNT_W = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             game_over_q_r;

    // Frame counter: cleared on a game_over rising edge so blinking starts visible
    always_ff @(posedge clock_25) begin
        if (reset) begin
            frame_cnt_r   <= {CNT_W{1'b0}};
            game_over_q_r <= 1'b0;
        end else begin
            game_over_q_r <= game_over;
            if (game_over && !game_over_q_r) begin
                frame_cnt_r <= {CNT_W{1'b0}};
            end else if ((X == {PIX_W{1'b0}}) && (Y == {PIX_W{1'b0}})) begin
                if (frame_cnt_r == CNT_W'(2 * BLINK_HALF - 1)) begin
                    frame_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Border is dark during the second half of each blink period while game over
    always_comb begin
        if (!game_over) begin
            border_vis_s = 1'b1;
        end else if (int'(frame_cnt_r) < BLINK_HALF) begin
            border_vis_s = 1'b1;
        end else begin
            border_vis_s = 1'b0;
        end
    end
`else
    logic unused_game_over_s;
    assign unused_game_over_s = game_over;
    assign border_vis_s       = 1'b1;
`endif

    // Stage 1 registers, then the flag delay line aligned with rom_data
    always_ff @(posedge clock_25) begin
        if (reset) begin
            border_r   <= 1'b0;
            text_r     <= 1'b0;
            game_r     <= 1'b0;
            rom_x      <= 8'd0;
            rom_y      <= 4'd0;
            field_idx  <= 3'd0;
            border_d_r <= {ROM_LAT{1'b0}};
            text_d_r   <= {ROM_LAT{1'b0}};
            game_d_r   <= {ROM_LAT{1'b0}};
        end else begin
            border_r      <= border_s && border_vis_s;
            text_r        <= hit_s;
            game_r        <= game_s;
            rom_x         <= rx_s;
            rom_y         <= ry_s;
            field_idx     <= fi_s;
            border_d_r[0] <= border_r;
            text_d_r[0]   <= text_r;
            game_d_r[0]   <= game_r;
            for (int i = 1; i < ROM_LAT; i++) begin
                border_d_r[i] <= border_d_r[i-1];
                text_d_r[i]   <= text_d_r[i-1];
                game_d_r[i]   <= game_d_r[i-1];
            end
        end
    end

    // A text hit shows the glyph bit and hides the border; rom_data is ignored otherwise
    always_comb begin
        if (text_d_r[ROM_LAT-1]) begin
            pixel_on = rom_data;
        end else begin
            pixel_on = border_d_r[ROM_LAT-1];
        end
    end

    assign game_area_o = game_d_r[ROM_LAT-1];

endmodule

// File: tb/tb_hud_frame_renderer.sv
module tb_hud_frame_renderer;

    localparam int ROM_LAT = 1;
    localparam int FX [2] = '{108, 362};
    localparam int FW [2] = '{63, 81};
    localparam int FB [2] = '{0, 62};

    typedef struct {
        int         due;
        logic [7:0] rx;
        logic [3:0] ry;
        logic [2:0] fi;
        logic       pix;
        logic       game;
    } exp_t;

    logic       clock_25;
    logic       reset;
    logic [9:0] X;
    logic [9:0] Y;
    logic       rom_data;
    logic       game_over;
    logic [7:0] rom_x;
    logic [3:0] rom_y;
    logic [2:0] field_idx;
    logic       pixel_on;
    logic       game_area_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1 [$];
    exp_t q2 [$];
    exp_t m;
    logic [ROM_LAT-1:0] rom_pipe;

    hud_frame_renderer #(.ROM_LAT(ROM_LAT)) dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .X           (X),
        .Y           (Y),
        .rom_data    (rom_data),
        .game_over   (game_over),
        .rom_x       (rom_x),
        .rom_y       (rom_y),
        .field_idx   (field_idx),
        .pixel_on    (pixel_on),
        .game_area_o (game_area_o)
    );

    initial begin
        clock_25 = 1'b0;
        forever #20 clock_25 = ~clock_25;
    end

    // Glyph content: lit when the address has even parity (so address 0,0 reads 1)
    function automatic logic glyph(input logic [7:0] rx, input logic [3:0] ry);
        logic [11:0] v;
        v = {rx, ry};
        return ~(^v);
    endfunction

    // ROM with ROM_LAT cycles of latency
    always @(posedge clock_25) begin
        rom_pipe[0] <= glyph(rom_x, rom_y);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    always @(posedge clock_25) cyc <= cyc + 1;

    function automatic void model(input int x, input int y, input bit vis,
                                  output logic [7:0] rx, output logic [3:0] ry,
                                  output logic [2:0] fi, output logic pix,
                                  output logic game);
        bit g, outer, hit;
        g     = (x >= 58) && (x <= 678) && (y >= 43) && (y <= 448);
        outer = (x >= 53) && (x <= 683) && (y >= 38) && (y <= 453);
        hit = 1'b0; rx = 8'd0; ry = 4'd0; fi = 3'd0;
        if ((y >= 460) && (y <= 475)) begin
            for (int k = 0; k < 2; k++) begin
                if (!hit && (x >= FX[k]) && (x <= FX[k] + FW[k] - 1)) begin
                    hit = 1'b1;
                    rx  = 8'(x - FX[k] + FB[k]);
                    ry  = 4'(y - 460);
                    fi  = 3'(k);
                end
            end
        end
        pix  = hit ? glyph(rx, ry) : (outer && !g && vis);
        game = g;
    endfunction

    task automatic drive(input int x, input int y, input bit rst, input bit go, input bit vis);
        exp_t e;
        int   c;
        @(posedge clock_25);
        #1;
        X = 10'(x);
        Y = 10'(y);
        reset = rst;
        game_over = go;
        c = cyc;
        if (rst) begin
            while (q1.size() > 0 && q1[$].due > c) void'(q1.pop_back());
            while (q2.size() > 0 && q2[$].due > c) void'(q2.pop_back());
            e.rx = 8'd0; e.ry = 4'd0; e.fi = 3'd0; e.pix = 1'b0; e.game = 1'b0;
            e.due = c + 1;
            q1.push_back(e);
            for (int k = 1; k <= ROM_LAT + 1; k++) begin
                e.due = c + k;
                q2.push_back(e);
            end
        end else begin
            model(x, y, vis, e.rx, e.ry, e.fi, e.pix, e.game);
            e.due = c + 1;
            q1.push_back(e);
            e.due = c + 1 + ROM_LAT;
            q2.push_back(e);
        end
    endtask

    // Scoreboard: compare DUT outputs against queued expectations on the falling edge
    always @(negedge clock_25) begin
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            m = q1.pop_front();
            checks++;
            assert (rom_x === m.rx) else begin
                errors++;
                $error("FAIL rom_x cyc=%0d got %0d want %0d", cyc, rom_x, m.rx);
            end
            checks++;
            assert (rom_y === m.ry) else begin
                errors++;
                $error("FAIL rom_y cyc=%0d got %0d want %0d", cyc, rom_y, m.ry);
            end
            checks++;
            assert (field_idx === m.fi) else begin
                errors++;
                $error("FAIL field_idx cyc=%0d got %0d want %0d", cyc, field_idx, m.fi);
            end
        end
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            m = q2.pop_front();
            checks++;
            assert (pixel_on === m.pix) else begin
                errors++;
                $error("FAIL pixel_on cyc=%0d got %b want %b", cyc, pixel_on, m.pix);
            end
            checks++;
            assert (game_area_o === m.game) else begin
                errors++;
                $error("FAIL game_area_o cyc=%0d got %b want %b", cyc, game_area_o, m.game);
            end
        end
    end

    initial begin
        bit vis;
        reset = 1'b1;
        game_over = 1'b0;
        X = 10'd0;
        Y = 10'd0;
        // Reset state
        repeat (3) drive(0, 0, 1'b1, 1'b0, 1'b1);
        // Border and game-area boundaries
        drive(53, 38, 1'b0, 1'b0, 1'b1);
        drive(58, 43, 1'b0, 1'b0, 1'b1);
        drive(57, 43, 1'b0, 1'b0, 1'b1);
        drive(683, 453, 1'b0, 1'b0, 1'b1);
        drive(684, 453, 1'b0, 1'b0, 1'b1);
        drive(52, 38, 1'b0, 1'b0, 1'b1);
        drive(678, 448, 1'b0, 1'b0, 1'b1);
        drive(679, 448, 1'b0, 1'b0, 1'b1);
        drive(300, 200, 1'b0, 1'b0, 1'b1);
        // Text fields and their edges
        drive(108, 460, 1'b0, 1'b0, 1'b1);
        drive(170, 461, 1'b0, 1'b0, 1'b1);
        drive(171, 461, 1'b0, 1'b0, 1'b1);
        drive(362, 470, 1'b0, 1'b0, 1'b1);
        drive(442, 475, 1'b0, 1'b0, 1'b1);
        drive(443, 475, 1'b0, 1'b0, 1'b1);
        drive(361, 470, 1'b0, 1'b0, 1'b1);
        drive(200, 465, 1'b0, 1'b0, 1'b1);
        drive(362, 476, 1'b0, 1'b0, 1'b1);
        drive(108, 459, 1'b0, 1'b0, 1'b1);
        drive(1000, 1000, 1'b0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        // Reset pulsed in the text band flushes the pipeline
        drive(362, 465, 1'b0, 1'b0, 1'b1);
        drive(400, 470, 1'b1, 1'b0, 1'b1);
        drive(362, 466, 1'b0, 1'b0, 1'b1);
        drive(363, 467, 1'b0, 1'b0, 1'b1);
        drive(53, 100, 1'b0, 1'b0, 1'b1);
        drive(120, 462, 1'b0, 1'b0, 1'b1);
        // Blink: game_over rises, then sample a border pixel once per frame
        drive(300, 200, 1'b0, 1'b1, 1'b1);
        for (int f = 0; f < 40; f++) begin
`ifdef HUD_BORDER_BLINK_EN
            vis = ((f % 32) < 16);
`else
            vis = 1'b1;
`endif
            drive(53, 38, 1'b0, 1'b1, vis);
            drive(0, 0, 1'b0, 1'b1, vis);
        end
        drive(300, 200, 1'b0, 1'b0, 1'b1);
        drive(60, 40, 1'b0, 1'b0, 1'b1);
        // Drain the scoreboard
        repeat (ROM_LAT + 3) @(posedge clock_25);
        #25;
        checks++;
        assert ((q1.size() + q2.size()) == 0) else begin
            errors++;
            $error("FAIL drain pending got %0d want 0", q1.size() + q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
